// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared state encoding for the fout period meter
package freq_meas_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_LOW  = 3'd1;
    localparam logic [STATE_W-1:0] WAIT_RISE = 3'd2;
    localparam logic [STATE_W-1:0] MEASURE   = 3'd3;
    localparam logic [STATE_W-1:0] HOLD      = 3'd4;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - fin synchronizer with rising-edge detect
// clk  : system clock
// rst  : asynchronous active-high reset, all flops to 0
// d    : asynchronous input (divider fout)
// s    : synchronized level
// rise : one-cycle pulse on a synchronized 0->1 transition
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

endmodule

// File: rtl/fout_period_meter.sv
// rtl/fout_period_meter.sv - measures one fout period and its high time in clk cycles
// clk        : system clock
// RST        : asynchronous active-high reset
// fin        : divided clock under test
// start      : one-cycle measurement request, honoured only in IDLE
// meas_ready : consumer accepts the result
// meas_valid : result available, period/high_time stable while set
// period     : clk cycles rising edge to rising edge
// high_time  : clk cycles fin was high within that period
// busy       : any state other than IDLE
// timeout    : sticky, last measurement aborted by the watchdog
module fout_period_meter
    import freq_meas_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_CYCLES  = 1000000
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             fin,
    input  logic             start,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             busy,
    output logic             timeout
);

    // wd is compared before incrementing, so the abort happens on the
    // MAX_CYCLES-th active cycle rather than one later.
    localparam logic [WIDTH-1:0] WD_LAST = WIDTH'(MAX_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] wd;
    logic             s;
    logic             rise;
    logic             wd_expired;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk (clk),
        .rst (RST),
        .d   (fin),
        .s   (s),
        .rise(rise)
    );

    assign wd_expired = (wd == WD_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            wd         <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WAIT_LOW;
                        timeout <= 1'b0;
                        wd      <= '0;
                    end
                end

                // Starting while fin is already high would measure a
                // truncated first pulse, so wait for a low level first.
                WAIT_LOW: begin
                    if (wd_expired) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                        if (!s) begin
                            state <= WAIT_RISE;
                        end
                    end
                end

                // The rising-edge cycle itself is the first cycle of the
                // period and is high, hence both counters start at 1.
                WAIT_RISE: begin
                    if (wd_expired) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= WIDTH'(1);
                            hi    <= WIDTH'(1);
                        end
                    end
                end

                // A closing edge wins over a simultaneous watchdog expiry:
                // the period is complete, so report it.
                MEASURE: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hi;
                        meas_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (wd_expired) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wd  <= wd + 1'b1;
                        cnt <= cnt + 1'b1;
                        hi  <= hi + {{(WIDTH-1){1'b0}}, s};
                    end
                end

                HOLD: begin
                    if (meas_ready) begin
                        meas_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    meas_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fout_period_meter.sv
// tb/tb_fout_period_meter.sv - scoreboard bench for fout_period_meter
module tb_fout_period_meter;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         fin;
    logic         start;
    logic         meas_ready;
    logic         meas_valid;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         busy;
    logic         timeout;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    int fin_mode = 0;
    int gen_n    = 8;
    int gen_h    = 4;
    int ph       = 0;

    always #5 clk = ~clk;

    fout_period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .MAX_CYCLES (64)
    ) dut (
        .clk       (clk),
        .RST       (rst),
        .fin       (fin),
        .start     (start),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .period    (period),
        .high_time (high_time),
        .busy      (busy),
        .timeout   (timeout)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int p, input int h);
        exp_t e;
        e.p = W'(p);
        e.h = W'(h);
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // fin generator: mode 0 constant low, 1 constant high, 2 periodic gen_n/gen_h
    initial begin
        fin = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ph >= gen_n - 1) ph = 0;
            else ph++;
            case (fin_mode)
                0:       fin = 1'b0;
                1:       fin = 1'b1;
                default: fin = (ph < gen_h);
            endcase
        end
    end

    // Monitor: every accepted result is popped and compared.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && meas_valid && meas_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got period %0d high_time %0d, expected no result",
                         period, high_time);
            end else begin
                e = sb_q.pop_front();
                check("sb_period", period, e.p);
                check("sb_high_time", high_time, e.h);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst        = 1'b1;
        start      = 1'b0;
        meas_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", meas_valid, 0);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        cyc();

        // 1: period 8 / high 4, consumer always ready
        fin_mode = 2; gen_n = 8; gen_h = 4; meas_ready = 1'b1;
        repeat (10) cyc();
        push_exp(8, 4);
        pulse_start();
        wait_valid(ok);
        check("t1_valid_seen", W'(ok), 1);
        @(negedge clk);
        check("t1_valid_one_cycle", meas_valid, 0);
        check("t1_busy_after", busy, 0);
        cyc();

        // 2: period 5 / high 3, back-pressure for 10 cycles
        gen_n = 5; gen_h = 3; meas_ready = 1'b0;
        repeat (10) cyc();
        push_exp(5, 3);
        pulse_start();
        wait_valid(ok);
        check("t2_valid_seen", W'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", meas_valid, 1);
            check("t2_hold_period", period, 5);
            check("t2_hold_high", high_time, 3);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        meas_ready = 1'b1;
        @(posedge clk);
        #1;
        meas_ready = 1'b0;
        @(negedge clk);
        check("t2_valid_after", meas_valid, 0);
        check("t2_busy_after", busy, 0);
        cyc();

        // 3: fin stuck high, watchdog fires after 64 active cycles
        meas_ready = 1'b1; fin_mode = 1;
        repeat (5) cyc();
        pulse_start();
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("t3_timeout_early", timeout, 0);
        check("t3_busy_early", busy, 1);
        @(negedge clk);
        check("t3_timeout", timeout, 1);
        check("t3_busy", busy, 0);
        check("t3_valid", meas_valid, 0);
        cyc();
        pulse_start();
        @(negedge clk);
        check("t3_timeout_cleared", timeout, 0);
        check("t3_busy_restart", busy, 1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3_second_abort", W'(ok), 1);
        check("t3_second_timeout", timeout, 1);

        // 6: fin stuck low, passes WAIT_LOW then times out in WAIT_RISE
        fin_mode = 0;
        repeat (5) cyc();
        pulse_start();
        repeat (62) @(posedge clk);
        @(negedge clk);
        check("t6_timeout_early", timeout, 0);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (timeout) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_timeout_seen", W'(ok), 1);
        check("t6_busy", busy, 0);
        cyc();

        // 4: start mid-high-pulse, extra starts while busy and in handshake
        fin_mode = 2; gen_n = 8; gen_h = 4; meas_ready = 1'b1;
        repeat (10) cyc();
        for (int i = 0; i < 40; i++) begin
            if (ph == 2 && fin) break;
            cyc();
        end
        check("t4_phase_found", W'(fin), 1);
        push_exp(8, 4);
        pulse_start();
        @(negedge clk);
        check("t4_busy", busy, 1);
        repeat (4) cyc();
        pulse_start();
        wait_valid(ok);
        check("t4_valid_seen", W'(ok), 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_valid_after", meas_valid, 0);
        check("t4_busy_after", busy, 0);
        repeat (40) @(negedge clk);
        check("t4_no_restart", busy, 0);
        cyc();

        // 5: async reset in MEASURE, then a clean period-12 measurement
        gen_n = 12; gen_h = 6;
        repeat (15) cyc();
        for (int i = 0; i < 30; i++) begin
            if (ph == 6) break;
            cyc();
        end
        push_exp(12, 6);
        pulse_start();
        repeat (12) cyc();
        check("t5_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", meas_valid, 0);
        check("t5_rst_period", period, 0);
        check("t5_rst_high", high_time, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_timeout", timeout, 0);
        sb_q.delete();
        cyc();
        rst = 1'b0;
        cyc();
        push_exp(12, 6);
        pulse_start();
        wait_valid(ok);
        check("t5_valid_seen", W'(ok), 1);
        @(negedge clk);
        check("t5_valid_after", meas_valid, 0);
        repeat (5) cyc();

        check("sb_empty", W'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
